// File: rtl/window_feeder_pkg.sv
// rtl/window_feeder_pkg.sv - shared FSM and window position encodings for window_feeder
package window_feeder_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    WM_INTERIOR  = 4'd0,
    WM_TOP_LEFT  = 4'd1,
    WM_TOP       = 4'd2,
    WM_TOP_RIGHT = 4'd3,
    WM_LEFT      = 4'd4,
    WM_RIGHT     = 4'd5,
    WM_BOT_LEFT  = 4'd6,
    WM_BOT       = 4'd7,
    WM_BOT_RIGHT = 4'd8
  } wmode_t;

  // Row-buffer ring has three slots; step the slot index modulo 3.
  function automatic logic [1:0] slot_inc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic logic [1:0] slot_dec(input logic [1:0] s);
    return (s == 2'd0) ? 2'd2 : s - 2'd1;
  endfunction

endpackage

// File: rtl/window_clamp.sv
// rtl/window_clamp.sv - replicate-clamps 3x3 neighbour coordinates and classifies the centre position
module window_clamp
  import window_feeder_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CW    = 3,
  parameter int RW    = 3
) (
  input  logic [RW-1:0] i_row,
  input  logic [CW-1:0] i_col,
  output logic [RW-1:0] o_row_up,
  output logic [RW-1:0] o_row_dn,
  output logic [CW-1:0] o_col_lf,
  output logic [CW-1:0] o_col_rt,
  output logic [3:0]    o_write_mode
);

  logic w_top, w_bot, w_left, w_right;

  assign w_top   = (i_row == '0);
  assign w_bot   = (i_row == RW'(IMG_H - 1));
  assign w_left  = (i_col == '0);
  assign w_right = (i_col == CW'(IMG_W - 1));

  assign o_row_up = w_top   ? i_row : i_row - 1'b1;
  assign o_row_dn = w_bot   ? i_row : i_row + 1'b1;
  assign o_col_lf = w_left  ? i_col : i_col - 1'b1;
  assign o_col_rt = w_right ? i_col : i_col + 1'b1;

  // IMG_W, IMG_H >= 2 so top/bottom and left/right never coincide.
  always_comb begin
    o_write_mode = WM_INTERIOR;
    if (w_top) begin
      o_write_mode = w_left ? WM_TOP_LEFT : (w_right ? WM_TOP_RIGHT : WM_TOP);
    end else if (w_bot) begin
      o_write_mode = w_left ? WM_BOT_LEFT : (w_right ? WM_BOT_RIGHT : WM_BOT);
    end else if (w_left) begin
      o_write_mode = WM_LEFT;
    end else if (w_right) begin
      o_write_mode = WM_RIGHT;
    end
  end

endmodule

// File: rtl/window_feeder.sv
// rtl/window_feeder.sv - buffers a raster pixel stream in a 3-row ring and emits clamped 3x3 windows
module window_feeder
  import window_feeder_pkg::*;
#(
  parameter int length = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [length-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [length-1:0] data_out1,
  output logic [length-1:0] data_out2,
  output logic [length-1:0] data_out3,
  output logic [length-1:0] data_out4,
  output logic [length-1:0] data_out5,
  output logic [length-1:0] data_out6,
  output logic [length-1:0] data_out7,
  output logic [length-1:0] data_out8,
  output logic [length-1:0] data_out9,
  output logic [3:0]        write_mode,
  output logic              row_even,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  localparam logic [RW-1:0] PEN_ROW  = RW'(IMG_H - 2);

  state_t            r_state;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [1:0]        r_wslot;
  logic [1:0]        r_cslot;
  logic              r_have_row0;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [length-1:0] r_mem [3][IMG_W];

  logic              w_in_fire, w_out_fire;
  logic [RW-1:0]     w_row_up, w_row_dn;
  logic [CW-1:0]     w_col_lf, w_col_rt;
  logic [3:0]        w_mode;
  logic [1:0]        w_slot_up, w_slot_dn;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  window_clamp #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW),
    .RW    (RW)
  ) u_clamp (
    .i_row        (r_row),
    .i_col        (r_col),
    .o_row_up     (w_row_up),
    .o_row_dn     (w_row_dn),
    .o_col_lf     (w_col_lf),
    .o_col_rt     (w_col_rt),
    .o_write_mode (w_mode)
  );

  // A clamped neighbour row equal to the centre row reuses the centre slot.
  assign w_slot_up = (w_row_up == r_row) ? r_cslot : slot_dec(r_cslot);
  assign w_slot_dn = (w_row_dn == r_row) ? r_cslot : slot_inc(r_cslot);

  always_ff @(posedge clk) begin
    if (!rst && w_in_fire) begin
      r_mem[r_wslot][r_col] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_col       <= '0;
      r_row       <= '0;
      r_wslot     <= 2'd0;
      r_cslot     <= 2'd0;
      r_have_row0 <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_fire) begin
            if (r_col == LAST_COL) begin
              r_col   <= '0;
              r_wslot <= slot_inc(r_wslot);
              if (r_have_row0) begin
                r_state     <= ST_EMIT;
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b1;
              end else begin
                r_have_row0 <= 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (w_out_fire) begin
            if (r_col == LAST_COL) begin
              r_col   <= '0;
              r_row   <= r_row + 1'b1;
              r_cslot <= slot_inc(r_cslot);
              // Last buffered row has no successor to load; emit it directly.
              if (r_row == PEN_ROW) begin
                r_state <= ST_DRAIN;
              end else begin
                r_state     <= ST_LOAD;
                r_in_ready  <= 1'b1;
                r_out_valid <= 1'b0;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_out_fire) begin
            if (r_col == LAST_COL) begin
              r_state     <= ST_LOAD;
              r_col       <= '0;
              r_row       <= '0;
              r_wslot     <= 2'd0;
              r_cslot     <= 2'd0;
              r_have_row0 <= 1'b0;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: begin
          r_state     <= ST_LOAD;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign row_even  = ~r_row[0];
  assign out_last  = r_out_valid && (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign write_mode = r_out_valid ? w_mode : WM_INTERIOR;

  // Gated so stale buffer contents never appear on the outputs outside a window.
  assign data_out1 = r_out_valid ? r_mem[w_slot_up][w_col_lf] : '0;
  assign data_out2 = r_out_valid ? r_mem[w_slot_up][r_col]    : '0;
  assign data_out3 = r_out_valid ? r_mem[w_slot_up][w_col_rt] : '0;
  assign data_out4 = r_out_valid ? r_mem[r_cslot][w_col_lf]   : '0;
  assign data_out5 = r_out_valid ? r_mem[r_cslot][r_col]      : '0;
  assign data_out6 = r_out_valid ? r_mem[r_cslot][w_col_rt]   : '0;
  assign data_out7 = r_out_valid ? r_mem[w_slot_dn][w_col_lf] : '0;
  assign data_out8 = r_out_valid ? r_mem[w_slot_dn][r_col]    : '0;
  assign data_out9 = r_out_valid ? r_mem[w_slot_dn][w_col_rt] : '0;

endmodule

// File: tb/tb_window_feeder.sv
// tb/tb_window_feeder.sv - self-checking bench for window_feeder
module tb_window_feeder;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] in_data;
  logic in_valid, in_ready, out_valid, out_ready, out_last, row_even;
  logic [3:0] write_mode;
  logic [DW-1:0] d1, d2, d3, d4, d5, d6, d7, d8, d9;

  always #5 clk = ~clk;

  window_feeder #(.length(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .data_out1(d1), .data_out2(d2), .data_out3(d3), .data_out4(d4), .data_out5(d5),
    .data_out6(d6), .data_out7(d7), .data_out8(d8), .data_out9(d9),
    .write_mode(write_mode), .row_even(row_even), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  typedef struct packed {
    logic [8:0][DW-1:0] d;
    logic [3:0] wm;
    logic re;
    logic last;
  } win_t;

  typedef struct {
    int r;
    int c;
    int d[9];
    int wm;
    int re;
    int last;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] img [H][W];
  logic [DW-1:0] pix_q[$];
  win_t exp_q[$];
  win_t got_q[$];
  int g_cycle = 0;
  int frame_px = 0;
  int t16 = -1;
  int t_first = -1;
  int ready_viol = 0;
  int n_last = 0;
  vec_t tbl[9];

  function automatic int clampi(int v, int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic win_t model_win(int r, int c);
    win_t w;
    int cr, cc;
    int wm_tab[3][3] = '{'{1, 2, 3}, '{4, 0, 5}, '{6, 7, 8}};
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        w.d[(dr + 1) * 3 + (dc + 1)] = img[clampi(r + dr, H - 1)][clampi(c + dc, W - 1)];
    cr = (r == 0) ? 0 : ((r == H - 1) ? 2 : 1);
    cc = (c == 0) ? 0 : ((c == W - 1) ? 2 : 1);
    w.wm = 4'(wm_tab[cr][cc]);
    w.re = ((r % 2) == 0);
    w.last = (r == H - 1) && (c == W - 1);
    return w;
  endfunction

  task automatic load_frame(input int rand_vals, input int base);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = rand_vals ? DW'($urandom_range(0, 65535)) : DW'(base + W * r + c);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        pix_q.push_back(img[r][c]);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back(model_win(r, c));
  endtask

  function automatic win_t sample();
    win_t w;
    w.d[0] = d1; w.d[1] = d2; w.d[2] = d3;
    w.d[3] = d4; w.d[4] = d5; w.d[5] = d6;
    w.d[6] = d7; w.d[7] = d8; w.d[8] = d9;
    w.wm = write_mode;
    w.re = row_even;
    w.last = out_last;
    return w;
  endfunction

  task automatic check_win(input string name, input win_t got, input win_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got d=%h wm=%0d re=%0b last=%0b expected d=%h wm=%0d re=%0b last=%0b",
               name, got.d, got.wm, got.re, got.last, exp.d, exp.wm, exp.re, exp.last);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic run_traffic(input int gap_pct, input int stall_pct, input int px_limit, input int budget);
    int cyc = 0;
    int sent = 0;
    bit prev_stall = 0;
    win_t prev_w, w, e;
    prev_w = '0;
    while (cyc < budget && !(pix_q.size() == 0 && exp_q.size() == 0) &&
           !(px_limit > 0 && sent >= px_limit)) begin
      @(negedge clk);
      cyc++;
      g_cycle++;
      w = sample();
      if (prev_stall) begin
        check_int("stall_valid_held", int'(out_valid), 1);
        check_win("stall_window_held", w, prev_w);
      end
      out_ready = ($urandom_range(0, 99) >= stall_pct);
      if (pix_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        in_valid = 1'b1;
        in_data = pix_q[0];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        void'(pix_q.pop_front());
        sent++;
        frame_px++;
        if (frame_px == 2 * W && t16 < 0) t16 = g_cycle;
      end
      if (out_valid && t_first < 0) t_first = g_cycle;
      if (out_valid && in_ready) ready_viol++;
      if (out_valid && out_ready) begin
        got_q.push_back(w);
        if (w.last) n_last++;
        if (exp_q.size() == 0) begin
          check_int("unexpected_window", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_win("window_stream", w, e);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_w = w;
    end
    if (cyc >= budget) check_int("traffic_timeout", cyc, -1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    g_cycle++;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    win_t e;
    int idx;
    tbl[0] = '{0, 0, '{0, 0, 1, 0, 0, 1, 8, 8, 9}, 1, 1, 0};
    tbl[1] = '{3, 4, '{19, 20, 21, 27, 28, 29, 35, 36, 37}, 0, 0, 0};
    tbl[2] = '{7, 7, '{54, 55, 55, 62, 63, 63, 62, 63, 63}, 8, 0, 1};
    tbl[3] = '{0, 7, '{6, 7, 7, 6, 7, 7, 14, 15, 15}, 3, 1, 0};
    tbl[4] = '{7, 0, '{48, 48, 49, 56, 56, 57, 56, 56, 57}, 6, 0, 0};
    tbl[5] = '{4, 0, '{24, 24, 25, 32, 32, 33, 40, 40, 41}, 4, 1, 0};
    tbl[6] = '{2, 7, '{14, 15, 15, 22, 23, 23, 30, 31, 31}, 5, 1, 0};
    tbl[7] = '{0, 3, '{2, 3, 4, 2, 3, 4, 10, 11, 12}, 2, 1, 0};
    tbl[8] = '{7, 3, '{50, 51, 52, 58, 59, 60, 58, 59, 60}, 7, 0, 0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("rst_out_valid", int'(out_valid), 0);
    check_int("rst_out_last", int'(out_last), 0);
    check_int("rst_write_mode", int'(write_mode), 0);
    check_int("rst_row_even", int'(row_even), 1);
    check_int("rst_in_ready", int'(in_ready), 1);
    e = '0;
    e.re = 1'b1;
    check_win("rst_data", sample(), e);
    rst = 1'b0;

    // Frame 8r+c, no stalls: full stream, vector table, latency
    got_q.delete(); n_last = 0; frame_px = 0; t16 = -1; t_first = -1; ready_viol = 0;
    load_frame(0, 0);
    run_traffic(0, 0, 0, 2000);
    check_int("a_window_count", got_q.size(), W * H);
    check_int("a_last_count", n_last, 1);
    check_int("a_first_valid_latency", t_first - t16, 1);
    check_int("a_in_ready_during_emit", ready_viol, 0);
    for (int i = 0; i < 9; i++) begin
      idx = tbl[i].r * W + tbl[i].c;
      for (int k = 0; k < 9; k++) e.d[k] = DW'(tbl[i].d[k]);
      e.wm = 4'(tbl[i].wm);
      e.re = tbl[i].re[0];
      e.last = tbl[i].last[0];
      if (idx < got_q.size())
        check_win($sformatf("vec_r%0d_c%0d", tbl[i].r, tbl[i].c), got_q[idx], e);
      else
        check_int($sformatf("vec_r%0d_c%0d_missing", tbl[i].r, tbl[i].c), got_q.size(), idx + 1);
    end

    // Same frame with gapped input and random back-pressure
    got_q.delete(); n_last = 0; ready_viol = 0;
    load_frame(0, 0);
    run_traffic(30, 40, 0, 5000);
    check_int("b_window_count", got_q.size(), W * H);
    check_int("b_last_count", n_last, 1);
    check_int("b_in_ready_during_emit", ready_viol, 0);

    // Reset after 20 input pixels, then a fresh random frame
    pix_q.delete(); exp_q.delete();
    load_frame(0, 500);
    run_traffic(20, 20, 20, 2000);
    pulse_reset();
    check_int("c_rst_out_valid", int'(out_valid), 0);
    check_int("c_rst_in_ready", int'(in_ready), 1);
    check_int("c_rst_out_last", int'(out_last), 0);
    pix_q.delete(); exp_q.delete(); got_q.delete(); n_last = 0;
    load_frame(1, 0);
    run_traffic(20, 30, 0, 5000);
    check_int("c_window_count", got_q.size(), W * H);
    check_int("c_last_count", n_last, 1);

    // Two back-to-back frames
    got_q.delete(); n_last = 0; ready_viol = 0;
    load_frame(0, 0);
    load_frame(0, 100);
    run_traffic(10, 25, 0, 8000);
    check_int("d_window_count", got_q.size(), 2 * W * H);
    check_int("d_last_count", n_last, 2);
    check_int("d_in_ready_during_emit", ready_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
